// File: rtl/axi_aw_w_rr_arbiter_if.sv
// rtl/axi_aw_w_rr_arbiter_if.sv - upstream AW/W masters and downstream AW/W channel bundle
interface axi_aw_w_rr_arbiter_if #(
    parameter int NUM_IN   = 4,
    parameter int AW_BITS  = 64,
    parameter int ID_WIDTH = 4,
    parameter int W_BITS   = 73,
    parameter int IDX_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
);
    logic [NUM_IN-1:0]          s_aw_valid;
    logic [NUM_IN-1:0]          s_aw_ready;
    logic [NUM_IN*ID_WIDTH-1:0] s_aw_id;
    logic [NUM_IN*AW_BITS-1:0]  s_aw_chan;
    logic [NUM_IN-1:0]          s_w_valid;
    logic [NUM_IN-1:0]          s_w_ready;
    logic [NUM_IN*W_BITS-1:0]   s_w_chan;
    logic [NUM_IN-1:0]          s_w_last;
    logic                       m_aw_valid;
    logic                       m_aw_ready;
    logic [IDX_W+ID_WIDTH-1:0]  m_aw_id;
    logic [AW_BITS-1:0]         m_aw_chan;
    logic                       m_w_valid;
    logic                       m_w_ready;
    logic [W_BITS-1:0]          m_w_chan;
    logic                       m_w_last;

    modport slave (
        input  s_aw_valid, s_aw_id, s_aw_chan, s_w_valid, s_w_chan, s_w_last,
        input  m_aw_ready, m_w_ready,
        output s_aw_ready, s_w_ready,
        output m_aw_valid, m_aw_id, m_aw_chan, m_w_valid, m_w_chan, m_w_last
    );

    modport master (
        output s_aw_valid, s_aw_id, s_aw_chan, s_w_valid, s_w_chan, s_w_last,
        output m_aw_ready, m_w_ready,
        input  s_aw_ready, s_w_ready,
        input  m_aw_valid, m_aw_id, m_aw_chan, m_w_valid, m_w_chan, m_w_last
    );
endinterface

// File: rtl/axi_aw_w_rr_arbiter.sv
// rtl/axi_aw_w_rr_arbiter.sv - round-robin AW arbiter with W steering by grant order
module axi_aw_w_rr_arbiter #(
    parameter int NUM_IN    = 4,
    parameter int AW_BITS   = 64,
    parameter int ID_WIDTH  = 4,
    parameter int W_BITS    = 73,
    parameter int ORD_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    axi_aw_w_rr_arbiter_if.slave   bus,
    output logic                   ord_full
);
    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int PTR_W = $clog2(ORD_DEPTH);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] lock_idx;
    logic             lock;
    logic [IDX_W-1:0] win;
    logic             found;
    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] ord_mem [ORD_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic [IDX_W-1:0] head;
    logic             ord_empty;
    logic             aw_hs;
    logic             w_pop;

    assign ord_full  = (count == (PTR_W+1)'(ORD_DEPTH));
    assign ord_empty = (count == '0);
    assign head      = ord_mem[rd_ptr];
    assign aw_hs     = bus.m_aw_valid & bus.m_aw_ready;
    assign w_pop     = bus.m_w_valid & bus.m_w_ready & bus.m_w_last;

    // Winner selection: held grant while locked, otherwise first valid from rr_ptr;
    // scanning downwards lets the nearest candidate overwrite farther ones.
    always_comb begin
        found = 1'b0;
        win   = lock_idx;
        cand  = '0;
        if (lock) begin
            found = 1'b1;
        end else if (!ord_full) begin
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
                if (cand >= (IDX_W+1)'(NUM_IN)) begin
                    cand = cand - (IDX_W+1)'(NUM_IN);
                end
                if (bus.s_aw_valid[cand[IDX_W-1:0]]) begin
                    found = 1'b1;
                    win   = cand[IDX_W-1:0];
                end
            end
        end
    end

    // AW pass-through from the winner; handshakes are suppressed while in reset
    // so no master believes an address was taken that the cleared FIFO forgets.
    always_comb begin
        bus.m_aw_valid = 1'b0;
        bus.m_aw_id    = '0;
        bus.m_aw_chan  = '0;
        bus.s_aw_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (win == IDX_W'(i)) begin
                bus.m_aw_id       = {win, bus.s_aw_id[i*ID_WIDTH +: ID_WIDTH]};
                bus.m_aw_chan     = bus.s_aw_chan[i*AW_BITS +: AW_BITS];
                bus.m_aw_valid    = found & bus.s_aw_valid[i] & ~rst;
                bus.s_aw_ready[i] = found & bus.s_aw_valid[i] & ~rst & bus.m_aw_ready;
            end
        end
    end

    // W steering from the master at the head of the order FIFO.
    always_comb begin
        bus.m_w_valid = 1'b0;
        bus.m_w_chan  = '0;
        bus.m_w_last  = 1'b0;
        bus.s_w_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!ord_empty && head == IDX_W'(i)) begin
                bus.m_w_valid    = bus.s_w_valid[i] & ~rst;
                bus.m_w_chan     = bus.s_w_chan[i*W_BITS +: W_BITS];
                bus.m_w_last     = bus.s_w_last[i];
                bus.s_w_ready[i] = bus.m_w_ready & ~rst;
            end
        end
    end

    // Order FIFO storage: record each granted master index.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            ord_mem[wr_ptr] <= win;
        end
    end

    // Arbiter and FIFO bookkeeping: lock, round-robin pointer, FIFO pointers/count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (aw_hs) begin
                lock   <= 1'b0;
                wr_ptr <= wr_ptr + PTR_W'(1);
                rr_ptr <= (win == IDX_W'(NUM_IN - 1)) ? '0 : win + IDX_W'(1);
            end else if (bus.m_aw_valid) begin
                lock     <= 1'b1;
                lock_idx <= win;
            end
            if (w_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + (PTR_W+1)'(aw_hs) - (PTR_W+1)'(w_pop);
        end
    end
endmodule

// File: tb/tb_axi_aw_w_rr_arbiter.sv
// tb/tb_axi_aw_w_rr_arbiter.sv - randomized and directed bench with queue-based reference model
module tb_axi_aw_w_rr_arbiter;
    localparam int N   = 4;
    localparam int AWB = 64;
    localparam int IDW = 4;
    localparam int WB  = 73;
    localparam int ORD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ord_full;
    logic mon_on = 1'b0;

    int total = 0;
    int bad   = 0;

    int rr;
    int held;
    int q[$];
    int grant_log[$];
    int k;
    int h;
    logic ev;
    logic ew;
    logic [N-1:0] oh;

    always #5 clk = ~clk;

    axi_aw_w_rr_arbiter_if #(.NUM_IN(N), .AW_BITS(AWB), .ID_WIDTH(IDW), .W_BITS(WB)) bus ();

    axi_aw_w_rr_arbiter #(
        .NUM_IN(N), .AW_BITS(AWB), .ID_WIDTH(IDW), .W_BITS(WB), .ORD_DEPTH(ORD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .ord_full(ord_full)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin
            bus.s_aw_id[i*IDW +: IDW]   = IDW'($urandom);
            bus.s_aw_chan[i*AWB +: AWB] = {$urandom, $urandom};
            bus.s_w_chan[i*WB +: WB]    = WB'({$urandom, $urandom, $urandom});
        end
    endtask

    // Reference model: compare at negedge, then advance model for the coming posedge.
    always @(negedge clk) begin
        if (mon_on) begin
            if (rst) begin
                chk("rst_m_aw_valid", 128'(bus.m_aw_valid), 128'(0));
                chk("rst_s_aw_ready", 128'(bus.s_aw_ready), 128'(0));
                chk("rst_m_w_valid", 128'(bus.m_w_valid), 128'(0));
                chk("rst_s_w_ready", 128'(bus.s_w_ready), 128'(0));
                rr = 0;
                held = -1;
                q.delete();
            end else begin
                k = -1;
                if (held >= 0) begin
                    k = held;
                end else if (q.size() < ORD) begin
                    for (int j = 0; j < N; j++) begin
                        if (k < 0 && bus.s_aw_valid[(rr + j) % N]) k = (rr + j) % N;
                    end
                end
                ev = (k >= 0) && bus.s_aw_valid[k];
                oh = (ev && bus.m_aw_ready) ? N'(1) << k : '0;
                chk("m_aw_valid", 128'(bus.m_aw_valid), 128'(ev));
                chk("s_aw_ready", 128'(bus.s_aw_ready), 128'(oh));
                if (ev) begin
                    chk("m_aw_id", 128'(bus.m_aw_id), 128'({2'(k), bus.s_aw_id[k*IDW +: IDW]}));
                    chk("m_aw_chan", 128'(bus.m_aw_chan), 128'(bus.s_aw_chan[k*AWB +: AWB]));
                end
                h  = (q.size() > 0) ? q[0] : -1;
                ew = (h >= 0) && bus.s_w_valid[h];
                oh = (h >= 0 && bus.m_w_ready) ? N'(1) << h : '0;
                chk("m_w_valid", 128'(bus.m_w_valid), 128'(ew));
                chk("s_w_ready", 128'(bus.s_w_ready), 128'(oh));
                if (h >= 0) begin
                    chk("m_w_chan", 128'(bus.m_w_chan), 128'(bus.s_w_chan[h*WB +: WB]));
                    chk("m_w_last", 128'(bus.m_w_last), 128'(bus.s_w_last[h]));
                end
                chk("ord_full", 128'(ord_full), 128'(q.size() == ORD));
                if (ew && bus.m_w_ready && bus.s_w_last[h]) void'(q.pop_front());
                if (ev && bus.m_aw_ready) begin
                    q.push_back(k);
                    grant_log.push_back(k);
                    rr = (k + 1) % N;
                    held = -1;
                end else if (ev) begin
                    held = k;
                end
            end
        end
    end

    initial begin
        bus.s_aw_valid = '0;
        bus.s_w_valid  = '0;
        bus.s_w_last   = '0;
        bus.m_aw_ready = 1'b0;
        bus.m_w_ready  = 1'b0;
        rand_payload();
        for (int i = 0; i < N; i++) bus.s_aw_id[i*IDW +: IDW] = IDW'(i + 8);
        rr = 0;
        held = -1;
        step(1);
        mon_on = 1'b1;
        step(1);
        rst = 1'b0;
        chk("reset_ord_full", 128'(ord_full), 128'(0));
        chk("reset_m_aw_valid", 128'(bus.m_aw_valid), 128'(0));

        // single master 2, id 3, 4-beat burst
        bus.s_aw_id[2*IDW +: IDW] = 4'd3;
        bus.s_aw_valid = 4'b0100;
        bus.m_aw_ready = 1'b1;
        bus.m_w_ready  = 1'b1;
        #1;
        chk("single_id", 128'(bus.m_aw_id), 128'({2'd2, 4'd3}));
        chk("single_w_blocked", 128'(bus.s_w_ready), 128'(0));
        step(1);
        bus.s_aw_valid = '0;
        bus.s_w_valid  = 4'b0100;
        for (int b = 0; b < 4; b++) begin
            bus.s_w_last = (b == 3) ? 4'b0100 : 4'b0000;
            step(1);
        end
        bus.s_w_valid = '0;
        bus.s_w_last  = '0;
        bus.s_aw_valid = 4'b1001;
        #1;
        chk("rr_after_single", 128'(bus.s_aw_ready), 128'(4'b1000));
        step(1);
        bus.s_aw_valid = '0;
        bus.s_w_valid = 4'b1000;
        bus.s_w_last  = 4'b1000;
        step(1);
        bus.s_w_valid = '0;
        bus.s_w_last  = '0;

        // round robin with fill to full
        grant_log.delete();
        bus.s_aw_valid = 4'b1011;
        step(6);
        chk("rr_cnt", 128'(grant_log.size()), 128'(4));
        chk("rr_g0", 128'(grant_log[0]), 128'(0));
        chk("rr_g1", 128'(grant_log[1]), 128'(1));
        chk("rr_g2", 128'(grant_log[2]), 128'(3));
        chk("rr_g3", 128'(grant_log[3]), 128'(0));
        chk("rr_full", 128'(ord_full), 128'(1));
        chk("rr_full_novalid", 128'(bus.m_aw_valid), 128'(0));
        bus.s_w_valid = 4'b1111;
        bus.s_w_last  = 4'b1111;
        step(3);
        bus.s_aw_valid = '0;
        chk("rr_g4", 128'(grant_log[4]), 128'(1));
        chk("rr_g5", 128'(grant_log[5]), 128'(3));
        step(8);
        bus.s_w_valid = '0;
        bus.s_w_last  = '0;

        // stability under m_aw_ready low
        grant_log.delete();
        bus.m_aw_ready = 1'b0;
        bus.s_aw_valid = 4'b0010;
        step(1);
        bus.s_aw_valid = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            chk("stab_idx", 128'(bus.m_aw_id[5:4]), 128'(1));
            step(1);
        end
        bus.m_aw_ready = 1'b1;
        step(1);
        bus.s_aw_valid = 4'b0001;
        step(1);
        bus.s_aw_valid = '0;
        chk("stab_g0", 128'(grant_log[0]), 128'(1));
        chk("stab_g1", 128'(grant_log[1]), 128'(0));
        bus.s_w_valid = 4'b1111;
        bus.s_w_last  = 4'b1111;
        step(3);

        // W order: AW 3 then 0, master 0 presents W first
        bus.s_w_valid = '0;
        bus.s_w_last  = '0;
        bus.s_aw_valid = 4'b1000;
        step(1);
        bus.s_aw_valid = 4'b0001;
        step(1);
        bus.s_aw_valid = '0;
        bus.s_w_valid = 4'b0001;
        bus.s_w_last  = 4'b0001;
        step(2);
        chk("word_hold0", 128'(bus.s_w_ready[0]), 128'(0));
        bus.s_w_valid = 4'b1001;
        step(1);
        bus.s_w_last = 4'b1001;
        step(1);
        chk("word_pass0", 128'(bus.s_w_ready[0]), 128'(1));
        step(1);
        bus.s_w_valid = '0;
        bus.s_w_last  = '0;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rand_payload();
            bus.s_aw_valid = N'($urandom);
            bus.s_w_valid  = N'($urandom);
            for (int i = 0; i < N; i++) bus.s_w_last[i] = ($urandom_range(0, 3) == 0);
            bus.m_aw_ready = ($urandom_range(0, 3) != 0);
            bus.m_w_ready  = ($urandom_range(0, 3) != 0);
            step(1);
        end

        // reset mid-burst with entries queued
        bus.s_aw_valid = '0;
        bus.s_w_valid  = '0;
        bus.s_w_last   = '0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.m_aw_ready = 1'b1;
        bus.m_w_ready  = 1'b1;
        bus.s_aw_valid = 4'b1110;
        step(3);
        bus.s_aw_valid = '0;
        bus.s_w_valid  = 4'b0010;
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bus.s_w_valid = '0;
        #1;
        chk("mid_rst_w_valid", 128'(bus.m_w_valid), 128'(0));
        chk("mid_rst_w_ready", 128'(bus.s_w_ready), 128'(0));
        chk("mid_rst_full", 128'(ord_full), 128'(0));
        bus.s_aw_valid = 4'b1010;
        #1;
        chk("mid_rst_grant", 128'(bus.s_aw_ready), 128'(4'b0010));
        step(2);
        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
